// File: rtl/prach_pkg.sv
// Shared definitions for the PRACH radix-3 DIT butterfly stages.
//   PRACH_DW    : external sample width (signed two's complement)
//   PRACH_IW    : internal width of the x2-scaled butterfly sums
//   SQRT3_2_Q17 : sqrt(3)/2 in Q1.17
//   cplx18_t    : packed complex sample {re, im}
//   phase_t     : position of a sample inside its {a, b, c} triplet
//   sat18       : clamp a widened value into the 18-bit signed range
package prach_pkg;

   localparam int PRACH_DW    = 18;
   localparam int PRACH_IW    = 21;
   localparam int SQRT3_2_Q17 = 113512;

   typedef struct packed {
      logic signed [PRACH_DW-1:0] re;
      logic signed [PRACH_DW-1:0] im;
   } cplx18_t;

   typedef enum logic [1:0] {
      PH_A = 2'd0,
      PH_B = 2'd1,
      PH_C = 2'd2
   } phase_t;

   function automatic logic signed [PRACH_DW-1:0] sat18(input logic signed [21:0] v);
      if (v > 22'sd131071) begin
         return 18'sd131071;
      end else if (v < -22'sd131072) begin
         return -18'sd131072;
      end else begin
         return v[PRACH_DW-1:0];
      end
   endfunction

endpackage

// File: rtl/prach_ditfft3_bf2_if.sv
// Stream bundle of the second radix-3 butterfly stage.
//   din_dr/din_di   : input sample (re/im), signed 18 bit
//   din_dv          : input sample valid
//   sync_in         : marks sample a of a triplet, meaningful with din_dv
//   dout_dr/dout_di : output sample (re/im), signed 18 bit
//   dout_dv         : output valid
//   sync_out        : marks X0 of an output triplet
//   dbg_phase       : triplet phase the next valid sample will take
// Handshake: there is no back-pressure. A sample transfers on every rising
// clk edge where din_dv is high; dout_* carry a result on every cycle where
// dout_dv is high and hold their last value otherwise.
// slave = the butterfly, master = the upstream source / downstream sink.
interface prach_ditfft3_bf2_if;
   import prach_pkg::*;

   logic signed [PRACH_DW-1:0] din_dr;
   logic signed [PRACH_DW-1:0] din_di;
   logic                       din_dv;
   logic                       sync_in;
   logic signed [PRACH_DW-1:0] dout_dr;
   logic signed [PRACH_DW-1:0] dout_di;
   logic                       dout_dv;
   logic                       sync_out;
   phase_t                     dbg_phase;

   modport slave (
      input  din_dr, din_di, din_dv, sync_in,
      output dout_dr, dout_di, dout_dv, sync_out, dbg_phase
   );

   modport master (
      output din_dr, din_di, din_dv, sync_in,
      input  dout_dr, dout_di, dout_dv, sync_out, dbg_phase
   );

endinterface

// File: rtl/prach_round_sat.sv
// Combinational round-half-up right shift by SCALE_SHIFT+1 followed by
// saturation to 18 bits. The +1 removes the x2 scaling the butterfly
// carries internally.
//   val : 21-bit signed x2-scaled sum
//   res : 18-bit signed rounded and saturated result
module prach_round_sat
   import prach_pkg::*;
#(
   parameter int SCALE_SHIFT = 1
) (
   input  logic signed [PRACH_IW-1:0] val,
   output logic signed [PRACH_DW-1:0] res
);

   localparam int                 SH   = SCALE_SHIFT + 1;
   localparam logic signed [21:0] HALF = 22'sd1 <<< (SH - 1);

   logic signed [21:0] ext;
   logic signed [21:0] biased;
   logic signed [21:0] shifted;

   // One guard bit keeps the rounding add from wrapping near full scale.
   assign ext     = {val[PRACH_IW-1], val};
   assign biased  = ext + HALF;
   assign shifted = biased >>> SH;
   assign res     = sat18(shifted);

endmodule

// File: rtl/prach_ditfft3_bf2.sv
// Second half of the radix-3 DIT butterfly. Consumes serial triplets
// {a, b, c} = {x0, x1+x2, x2-x1} and emits X0, X1, X2 serially, 4 cycles
// after the corresponding input sample.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stream bundle (slave side), see prach_ditfft3_bf2_if
// Internal sums are held at x2 scale so that k*c (k = sqrt(3)/2) can be
// rounded to an integer 2kc without losing the half-LSB.
module prach_ditfft3_bf2
   import prach_pkg::*;
#(
   parameter int SCALE_SHIFT = 1
) (
   input logic                clk,
   input logic                rst,
   prach_ditfft3_bf2_if.slave bus
);

   localparam logic signed [17:0] K_S    = 18'(SQRT3_2_Q17);
   localparam logic signed [35:0] P_HALF = 36'sd32768;

   phase_t                     phase;
   phase_t                     cur_ph;
   cplx18_t                    a_q;
   cplx18_t                    b_q;
   logic                       v1;
   logic [3:0]                 dv_sr;
   logic [3:0]                 sy_sr;
   logic signed [PRACH_DW-1:0] dout_r;
   logic signed [PRACH_DW-1:0] dout_i;

   // x2-scaled partial results, registered when c arrives
   logic signed [PRACH_IW-1:0] s0r_q, s0i_q, dr_q, di_q, pcr_q, pci_q;
   // X1/X2 waiting for their output slot
   logic signed [PRACH_IW-1:0] h1r, h1i, h2r, h2i;

   logic signed [35:0]         mr, mi, pr_rnd, pi_rnd;
   logic signed [PRACH_IW-1:0] a2r, a2i, br, bi;
   logic signed [PRACH_IW-1:0] s1r, s1i, s2r, s2i, sel_r, sel_i;
   logic signed [PRACH_DW-1:0] rs_r, rs_i;

   // sync_in realigns the current sample to a
   assign cur_ph = bus.sync_in ? PH_A : phase;

   // 2kc = round(k_q17 * c / 2^16), taken straight from the input as c arrives
   assign mr     = 36'(bus.din_dr) * 36'(K_S);
   assign mi     = 36'(bus.din_di) * 36'(K_S);
   assign pr_rnd = (mr + P_HALF) >>> 16;
   assign pi_rnd = (mi + P_HALF) >>> 16;

   assign a2r = 21'(a_q.re) <<< 1;
   assign a2i = 21'(a_q.im) <<< 1;
   assign br  = 21'(b_q.re);
   assign bi  = 21'(b_q.im);

   assign s1r = dr_q - pci_q;
   assign s1i = di_q + pcr_q;
   assign s2r = dr_q + pci_q;
   assign s2i = di_q - pcr_q;

   // X0 leaves the cycle after c; afterwards the hold registers drain
   assign sel_r = v1 ? s0r_q : h1r;
   assign sel_i = v1 ? s0i_q : h1i;

   prach_round_sat #(.SCALE_SHIFT(SCALE_SHIFT)) u_rs_re (.val(sel_r), .res(rs_r));
   prach_round_sat #(.SCALE_SHIFT(SCALE_SHIFT)) u_rs_im (.val(sel_i), .res(rs_i));

   // Control: phase counter, valid/sync delay line and output registers.
   // A mid-triplet gap simply leaves the phase where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase  <= PH_A;
         v1     <= 1'b0;
         dv_sr  <= '0;
         sy_sr  <= '0;
         dout_r <= '0;
         dout_i <= '0;
      end else begin
         dv_sr <= {dv_sr[2:0], bus.din_dv};
         sy_sr <= {sy_sr[2:0], bus.sync_in};
         v1    <= bus.din_dv && (cur_ph == PH_C);
         if (bus.din_dv) begin
            phase <= (cur_ph == PH_C) ? PH_A : phase_t'(cur_ph + 2'd1);
         end
         // dv_sr[2] is the valid that becomes dout_dv on this edge
         if (dv_sr[2]) begin
            dout_r <= rs_r;
            dout_i <= rs_i;
         end
      end
   end

   // Datapath registers carry no reset; validity is tracked above.
   always_ff @(posedge clk) begin
      if (bus.din_dv && (cur_ph == PH_A)) begin
         a_q <= {bus.din_dr, bus.din_di};
      end
      if (bus.din_dv && (cur_ph == PH_B)) begin
         b_q <= {bus.din_dr, bus.din_di};
      end
      if (bus.din_dv && (cur_ph == PH_C)) begin
         s0r_q <= a2r + (br <<< 1);
         s0i_q <= a2i + (bi <<< 1);
         dr_q  <= a2r - br;
         di_q  <= a2i - bi;
         pcr_q <= pr_rnd[PRACH_IW-1:0];
         pci_q <= pi_rnd[PRACH_IW-1:0];
      end
      if (v1) begin
         h1r <= s1r;
         h1i <= s1i;
         h2r <= s2r;
         h2i <= s2i;
      end else if (dv_sr[2]) begin
         h1r <= h2r;
         h1i <= h2i;
      end
   end

   assign bus.dout_dr   = dout_r;
   assign bus.dout_di   = dout_i;
   assign bus.dout_dv   = dv_sr[3];
   assign bus.sync_out  = sy_sr[3];
   assign bus.dbg_phase = phase;

endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// Bench for prach_ditfft3_bf2: one instance with SCALE_SHIFT=0 and one with
// the default shift, fed identical stimulus and checked every cycle against
// a DFT-3 reference model.
module tb_prach_ditfft3_bf2;
   import prach_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prach_ditfft3_bf2_if bus0 ();
   prach_ditfft3_bf2_if bus1 ();

   prach_ditfft3_bf2 #(.SCALE_SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   prach_ditfft3_bf2                    dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int n_checks = 0;
   int n_pass   = 0;

   // {check-enable, re, im} per expected output sample
   logic [36:0] exp_q0[$];
   logic [36:0] exp_q1[$];

   localparam int HMAX = 8192;
   int   cyc = 0;
   logic dv_h [0:HMAX-1];
   logic sy_h [0:HMAX-1];
   logic rst_h[0:HMAX-1];
   logic zero_pend = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   function automatic longint fdiv(input longint n, input longint d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   // 2*k*c with k = sqrt(3)/2 in Q1.17, rounded half up
   function automatic longint twokc(input longint c);
      return fdiv(113512 * c + 32768, 65536);
   endfunction

   function automatic longint finish_val(input longint s, input int sh);
      longint r;
      r = fdiv(s + (longint'(1) << sh), longint'(1) << (sh + 1));
      if (r > 131071) r = 131071;
      if (r < -131072) r = -131072;
      return r;
   endfunction

   task automatic model(input int sh, input longint ar, ai, br, bi, cr, ci,
                        output longint x0r, x0i, x1r, x1i, x2r, x2i);
      x0r = finish_val(2*ar + 2*br, sh);
      x0i = finish_val(2*ai + 2*bi, sh);
      x1r = finish_val(2*ar - br - twokc(ci), sh);
      x1i = finish_val(2*ai - bi + twokc(cr), sh);
      x2r = finish_val(2*ar - br + twokc(ci), sh);
      x2i = finish_val(2*ai - bi - twokc(cr), sh);
   endtask

   // ---------------- driver tasks ----------------
   task automatic put(input logic dv, input logic sy, input int r, input int i);
      bus0.din_dv = dv; bus0.sync_in = sy; bus0.din_dr = 18'(r); bus0.din_di = 18'(i);
      bus1.din_dv = dv; bus1.sync_in = sy; bus1.din_dr = 18'(r); bus1.din_di = 18'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) put(1'b0, 1'b0, 0, 0);
   endtask

   task automatic push_exp(input int sh, input longint r, input longint i);
      if (sh == 0) exp_q0.push_back({1'b1, 18'(r), 18'(i)});
      else         exp_q1.push_back({1'b1, 18'(r), 18'(i)});
   endtask

   task automatic send_triplet(input logic sy, input int ar, ai, br, bi, cr, ci);
      longint x0r, x0i, x1r, x1i, x2r, x2i;
      for (int sh = 0; sh < 2; sh++) begin
         model(sh, ar, ai, br, bi, cr, ci, x0r, x0i, x1r, x1i, x2r, x2i);
         push_exp(sh, x0r, x0i);
         push_exp(sh, x1r, x1i);
         push_exp(sh, x2r, x2i);
      end
      put(1'b1, sy, ar, ai);
      put(1'b1, 1'b0, br, bi);
      put(1'b1, 1'b0, cr, ci);
   endtask

   // a sample whose output slot exists but whose data is not defined
   task automatic send_loose(input logic sy, input int r, input int i);
      exp_q0.push_back('0);
      exp_q1.push_back('0);
      put(1'b1, sy, r, i);
   endtask

   function automatic int rv();
      logic [17:0] t;
      if ($urandom_range(0, 7) == 0) return ($urandom_range(0, 1) == 1) ? -131072 : 131071;
      t = 18'($urandom);
      return int'($signed(t));
   endfunction

   // ---------------- history + scoreboard ----------------
   always @(posedge clk) begin
      if (cyc + 1 < HMAX) begin
         dv_h[cyc+1]  <= bus0.din_dv;
         sy_h[cyc+1]  <= bus0.sync_in;
         rst_h[cyc+1] <= rst;
      end
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      int   n;
      logic edv, esy;
      logic [36:0] e0, e1;
      n = cyc;
      if (n > 0 && n < HMAX) begin
         edv = 1'b0;
         esy = 1'b0;
         if (n >= 3) begin
            edv = dv_h[n-3];
            esy = sy_h[n-3];
         end
         // a reset in the last four edges wipes the delayed valid/sync
         for (int k = n - 3; k <= n; k++) begin
            if (k >= 0 && rst_h[k]) begin
               edv = 1'b0;
               esy = 1'b0;
            end
         end
         if (rst_h[n]) zero_pend = 1'b1;
         chk("dout_dv_s0", longint'(bus0.dout_dv), longint'(edv));
         chk("dout_dv_s1", longint'(bus1.dout_dv), longint'(edv));
         chk("sync_out_s0", longint'(bus0.sync_out), longint'(esy));
         chk("sync_out_s1", longint'(bus1.sync_out), longint'(esy));
         if (edv) begin
            zero_pend = 1'b0;
            if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
               chk("exp_queue_nonempty", 0, 1);
            end else begin
               e0 = exp_q0.pop_front();
               e1 = exp_q1.pop_front();
               if (e0[36]) begin
                  chk("x_re_s0", longint'(bus0.dout_dr), longint'($signed(e0[35:18])));
                  chk("x_im_s0", longint'(bus0.dout_di), longint'($signed(e0[17:0])));
               end
               if (e1[36]) begin
                  chk("x_re_s1", longint'(bus1.dout_dr), longint'($signed(e1[35:18])));
                  chk("x_im_s1", longint'(bus1.dout_di), longint'($signed(e1[17:0])));
               end
            end
         end else if (zero_pend) begin
            chk("dout_zero_after_rst_s0", longint'(bus0.dout_dr) | longint'(bus0.dout_di), 0);
            chk("dout_zero_after_rst_s1", longint'(bus1.dout_dr) | longint'(bus1.dout_di), 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      longint x0r, x0i, x1r, x1i, x2r, x2i;

      // pin the model with hand-derived values
      model(0, 100, 0, 40, 0, 0, 0, x0r, x0i, x1r, x1i, x2r, x2i);
      chk("pin_t1_x0", x0r, 140);
      chk("pin_t1_x1", x1r, 80);
      chk("pin_t1_x2", x2r, 80);
      model(0, 0, 0, 0, 0, 1000, 0, x0r, x0i, x1r, x1i, x2r, x2i);
      chk("pin_t2_x1i", x1i, 866);
      chk("pin_t2_x2i", x2i, -866);
      model(0, 131071, 0, 131071, 0, 0, 0, x0r, x0i, x1r, x1i, x2r, x2i);
      chk("pin_t3_x0sat", x0r, 131071);
      chk("pin_t3_x1half", x1r, 65536);
      model(1, 100, 0, 40, 0, 0, 0, x0r, x0i, x1r, x1i, x2r, x2i);
      chk("pin_s1_x0", x0r, 70);

      bus0.din_dv = 1'b0; bus0.sync_in = 1'b0; bus0.din_dr = '0; bus0.din_di = '0;
      bus1.din_dv = 1'b0; bus1.sync_in = 1'b0; bus1.din_dr = '0; bus1.din_di = '0;
      rst = 1'b1;
      idle(3);
      chk("phase_after_rst", longint'(bus0.dbg_phase), 0);
      rst = 1'b0;
      idle(2);

      // directed cases
      send_triplet(1'b1, 100, 0, 40, 0, 0, 0);
      idle(6);
      send_triplet(1'b1, 0, 0, 0, 0, 1000, 0);
      idle(6);
      send_triplet(1'b1, 131071, 0, 131071, 0, 0, 0);
      idle(6);

      // continuous random triplets, sync on a only sometimes
      for (int t = 0; t < 200; t++) begin
         send_triplet((t == 0) || ($urandom_range(0, 1) == 1), rv(), rv(), rv(), rv(), rv(), rv());
      end

      // gap, two stray samples leave the phase at c, then realign with sync
      idle(5);
      send_loose(1'b0, rv(), rv());
      send_loose(1'b0, rv(), rv());
      idle(3);
      chk("phase_stray", longint'(bus0.dbg_phase), 2);
      for (int t = 0; t < 5; t++) begin
         send_triplet(t == 0, rv(), rv(), rv(), rv(), rv(), rv());
      end
      idle(4);

      // reset right after sample b; next triplet has no sync and must be a/b/c
      put(1'b1, 1'b1, rv(), rv());
      put(1'b1, 1'b0, rv(), rv());
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(6);
      chk("phase_post_rst", longint'(bus0.dbg_phase), 0);
      send_triplet(1'b0, -131072, 131071, 5000, -7000, -131072, -131072);
      send_triplet(1'b0, rv(), rv(), rv(), rv(), rv(), rv());
      idle(10);

      chk("exp_q0_drained", exp_q0.size(), 0);
      chk("exp_q1_drained", exp_q1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
